// File: rtl/wb_commit_queue.sv
// wb_commit_queue
//   Registered write-back commit stage between the MEM stage and the
//   register-file write port. Each incoming instruction is decoded into
//   (wen, rd, data). The result is buffered in a DEPTH-entry FIFO with
//   valid/ready handshakes on both sides. The head entry drives the
//   register-file write port and the forwarding path.
//
// Ports
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   flush            synchronous queue clear (retired_count untouched)
//   in_valid/ready   upstream handshake; in_ready depends on queue state only
//   in_instruction   instruction being retired (opcode and rd fields)
//   in_alu_data      ALU/other result
//   in_mem_data      memory load data
//   out_valid/ready  downstream handshake for the head entry
//   out_wen/addr/data  head entry, all driven to 0 while the queue is empty
//   retired_count    number of entries popped since reset
module wb_commit_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int OPCODE_LSB     = 27,
  parameter int RD_LSB         = 22,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_WIDTH-1:0]    in_instruction,
  input  logic [DATA_WIDTH-1:0]     in_alu_data,
  input  logic [DATA_WIDTH-1:0]     in_mem_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_wen,
  output logic [REG_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [COUNT_WIDTH-1:0]    retired_count
);

  localparam int OPC_W = INSTR_WIDTH - OPCODE_LSB;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [OPC_W-1:0]          opcode;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      dec_wen;
  logic [DATA_WIDTH-1:0]     dec_data;
  logic                      unused_instr;

  logic                      wen_mem  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign opcode = in_instruction[INSTR_WIDTH-1:OPCODE_LSB];
  assign rd     = in_instruction[RD_LSB+REG_ADDR_WIDTH-1:RD_LSB];
  // Instruction bits outside the opcode and rd fields are not needed here.
  assign unused_instr = ^in_instruction;

  // LW takes load data; SW and opcodes above 18 never write; r0 is never written.
  always_comb begin
    dec_data = in_alu_data;
    dec_wen  = 1'b0;
    if (opcode == '0) begin
      dec_data = in_mem_data;
      dec_wen  = 1'b1;
    end else if (opcode >= OPC_W'(2) && opcode <= OPC_W'(18)) begin
      dec_wen = 1'b1;
    end
    if (rd == '0) dec_wen = 1'b0;
  end

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_wen  = out_valid & wen_mem[rd_ptr];
  assign out_addr = out_valid ? rd_mem[rd_ptr]   : '0;
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      retired_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        retired_count <= retired_count + COUNT_WIDTH'(1);
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: it is only visible through the out_valid gating.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      wen_mem[wr_ptr]  <= dec_wen;
      rd_mem[wr_ptr]   <= rd;
      data_mem[wr_ptr] <= dec_data;
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
module tb_wb_commit_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [31:0] in_alu_data;
  logic [31:0] in_mem_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [31:0] retired_count;

  logic        in_ready4;
  logic        out_valid4;
  logic        out_wen4;
  logic [4:0]  out_addr4;
  logic [31:0] out_data4;
  logic [3:0]  retired_count4;

  always #5 clk = ~clk;

  wb_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wen(out_wen), .out_addr(out_addr), .out_data(out_data),
    .retired_count(retired_count)
  );

  wb_commit_queue #(.DEPTH(DEPTH), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_instruction(in_instruction), .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_wen(out_wen4), .out_addr(out_addr4), .out_data(out_data4),
    .retired_count(retired_count4)
  );

  // Reference model: a queue of decoded entries and a pop counter.
  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_ret;

  function automatic ent_t decode(logic [31:0] instr, logic [31:0] alu, logic [31:0] mem);
    ent_t e;
    int   opc;
    opc    = int'(instr[31:27]);
    e.rd   = instr[26:22];
    e.data = (opc == 0) ? mem : alu;
    e.wen  = ((opc == 0) || (opc >= 2 && opc <= 18)) && (e.rd != 5'd0);
    return e;
  endfunction

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      mq.delete();
      m_ret = 32'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) begin
        void'(mq.pop_front());
        m_ret = m_ret + 32'd1;
      end
      if (do_push) mq.push_back(decode(in_instruction, in_alu_data, in_mem_data));
    end
  end

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    ent_t h;
    bit   v;
    v = (mq.size() != 0);
    h = v ? mq[0] : '0;
    check("in_ready",  64'(in_ready),      64'(mq.size() < DEPTH));
    check("out_valid", 64'(out_valid),     64'(v));
    check("out_wen",   64'(out_wen),       64'(h.wen));
    check("out_addr",  64'(out_addr),      64'(h.rd));
    check("out_data",  64'(out_data),      64'(h.data));
    check("retired",   64'(retired_count), 64'(m_ret));
    check("in_ready4",  64'(in_ready4),      64'(mq.size() < DEPTH));
    check("out_valid4", 64'(out_valid4),     64'(v));
    check("out_wen4",   64'(out_wen4),       64'(h.wen));
    check("out_addr4",  64'(out_addr4),      64'(h.rd));
    check("out_data4",  64'(out_data4),      64'(h.data));
    check("retired4",   64'(retired_count4), 64'(m_ret[3:0]));
  endtask

  function automatic logic [31:0] mk(int opc, int rd);
    logic [31:0] r;
    r        = $urandom;
    r[31:27] = opc[4:0];
    r[26:22] = rd[4:0];
    return r;
  endfunction

  // Apply inputs just after an edge, then advance past the next edge.
  task automatic drive(bit v, logic [31:0] ins, logic [31:0] alu, logic [31:0] mem, bit ordy, bit fl);
    in_valid       = v;
    in_instruction = ins;
    in_alu_data    = alu;
    in_mem_data    = mem;
    out_ready      = ordy;
    flush          = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; in_alu_data = '0; in_mem_data = '0;

    fork
      forever begin
        @(negedge clk);
        if (checking) compare_model();
      end
    join_none

    // Reset with inputs active: they must be ignored.
    in_valid = 1'b1; out_ready = 1'b1; in_instruction = mk(4, 3);
    @(posedge clk); #1;
    checking = 1'b1;
    drive(1, mk(4, 3), 32'h1, 32'h2, 1, 0);
    rst_n = 1'b1;
    drive(0, '0, '0, '0, 0, 0);
    check("rst_valid",   64'(out_valid),     64'd0);
    check("rst_wen",     64'(out_wen),       64'd0);
    check("rst_addr",    64'(out_addr),      64'd0);
    check("rst_data",    64'(out_data),      64'd0);
    check("rst_retired", 64'(retired_count), 64'd0);
    check("rst_ready",   64'(in_ready),      64'd1);

    // LW to r5.
    drive(1, mk(0, 5), 32'h1234, 32'hDEADBEEF, 1, 0);
    check("lw_valid", 64'(out_valid), 64'd1);
    check("lw_wen",   64'(out_wen),   64'd1);
    check("lw_addr",  64'(out_addr),  64'd5);
    check("lw_data",  64'(out_data),  64'hDEADBEEF);
    drive(0, '0, '0, '0, 1, 0);
    check("lw_retired", 64'(retired_count), 64'd1);
    check("lw_empty",   64'(out_valid),     64'd0);

    // Non-writing forms: SW, rd==0, opcode above 18.
    drive(1, mk(1, 9), 32'hA1, 32'hB1, 1, 0);
    check("sw_wen",  64'(out_wen),  64'd0);
    check("sw_data", 64'(out_data), 64'hA1);
    drive(1, mk(3, 0), 32'hA2, 32'hB2, 1, 0);
    check("r0_wen",  64'(out_wen),  64'd0);
    check("r0_data", 64'(out_data), 64'hA2);
    drive(1, mk(25, 7), 32'hA3, 32'hB3, 1, 0);
    check("op25_wen",  64'(out_wen),  64'd0);
    check("op25_addr", 64'(out_addr), 64'd7);
    check("op25_data", 64'(out_data), 64'hA3);
    drive(0, '0, '0, '0, 1, 0);
    check("nw_retired", 64'(retired_count), 64'd4);

    // Fill, hold, and drain.
    drive(1, mk(2, 1), 32'h11, 32'h0, 0, 0);
    drive(1, mk(2, 2), 32'h22, 32'h0, 0, 0);
    check("full_ready", 64'(in_ready), 64'd0);
    drive(1, mk(2, 3), 32'h33, 32'h0, 0, 0);
    check("full_hold_data", 64'(out_data), 64'h11);
    drive(1, mk(2, 3), 32'h33, 32'h0, 1, 0);
    check("full_pop_data",  64'(out_data), 64'h22);
    check("full_pop_ready", 64'(in_ready), 64'd1);
    drive(0, '0, '0, '0, 1, 0);
    check("full_retired", 64'(retired_count), 64'd6);

    // Streaming: one entry per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1, mk(4, i), 32'(i), 32'hFFFF, 1, 0);
      check("stream_addr", 64'(out_addr), 64'(i));
      check("stream_data", 64'(out_data), 64'(i));
      check("stream_wen",  64'(out_wen),  64'(i != 0));
    end
    drive(0, '0, '0, '0, 1, 0);
    check("stream_retired", 64'(retired_count), 64'd16);
    check("wrap4_zero",     64'(retired_count4), 64'd0);

    // Flush beats a simultaneous push and pop.
    drive(1, mk(5, 4), 32'h44, 32'h0, 0, 0);
    drive(1, mk(5, 6), 32'h66, 32'h0, 0, 0);
    drive(1, mk(5, 8), 32'h88, 32'h0, 1, 1);
    check("flush_valid",   64'(out_valid),     64'd0);
    check("flush_ready",   64'(in_ready),      64'd1);
    check("flush_retired", 64'(retired_count), 64'd16);

    // 17th pop wraps the 4-bit counter to 1.
    drive(1, mk(6, 10), 32'h99, 32'h0, 1, 0);
    drive(0, '0, '0, '0, 1, 0);
    check("retired_17", 64'(retired_count),  64'd17);
    check("wrap4_one",  64'(retired_count4), 64'd1);

    // Random traffic including occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) >= 2);
      drive($urandom_range(0, 99) < 60, mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 31))),
            $urandom, $urandom, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) drive(0, '0, '0, '0, 1, 0);
    check("drain_valid", 64'(out_valid), 64'd0);

    rst_n = 1'b0;
    drive(1, mk(0, 1), 32'h5, 32'h6, 1, 0);
    rst_n = 1'b1;
    check("final_rst_retired", 64'(retired_count), 64'd0);
    check("final_rst_valid",   64'(out_valid),     64'd0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Parametrised successor to the combinational write-back select: registered write-back commit stage between MEM stage and register-file write port.
- Per instruction, chooses ALU result or memory load data from the opcode, derives register write-enable and destination, and buffers results in a DEPTH-entry FIFO with valid/ready on both sides.
- Exposes head entry for register-file write and forwarding, plus a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of ALU, memory and write-back data.
- INSTR_WIDTH, 32, instruction width.
- OPCODE_LSB, 27, LSB of opcode field; opcode = instruction[INSTR_WIDTH-1:OPCODE_LSB].
- RD_LSB, 22, LSB of destination field; rd = instruction[RD_LSB+REG_ADDR_WIDTH-1:RD_LSB].
- REG_ADDR_WIDTH, 5, register address width.
- DEPTH, 2, FIFO entries; power of two, >=2.
- COUNT_WIDTH, 32, retired counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous queue clear.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  queue can accept.
- in_instruction  input  INSTR_WIDTH  instruction being retired.
- in_alu_data  input  DATA_WIDTH  ALU/other result.
- in_mem_data  input  DATA_WIDTH  memory load data.
- out_valid  output  1  head entry valid.
- out_ready  input  1  register file consumes head.
- out_wen  output  1  head entry writes register file.
- out_addr  output  REG_ADDR_WIDTH  head destination register.
- out_data  output  DATA_WIDTH  head write-back data.
- retired_count  output  COUNT_WIDTH  entries popped since reset.

Behaviour:
- Reset (rst_n=0 at rising edge): FIFO empty, pointers 0, retired_count=0. out_valid, out_wen, out_addr and out_data read 0 the cycle after. All inputs are ignored on a reset edge.
- Decode, at push time:
  - opcode 0 (LW): data=in_mem_data, wen=1.
  - opcode 1 (SW): data=in_alu_data, wen=0.
  - opcode 2..18: data=in_alu_data, wen=1.
  - opcode >18: data=in_alu_data, wen=0.
  - wen is forced 0 when rd==0 (r0 is hardwired zero).
- Stored per entry: wen, rd, data.
- Push: in_valid & in_ready at the edge.
- Pop: out_valid & out_ready at the edge.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid = (count != 0). While empty, out_wen, out_addr and out_data are driven 0.
- out_wen is the head entry's wen gated by out_valid. The register file writes when out_wen & out_ready.
- Latency: an entry pushed at edge N appears at the head after edge N if the queue was empty. Otherwise it appears in FIFO order.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full: in_ready=0. A pop the same cycle does not enable a push that cycle; in_ready rises the cycle after.
- Empty: a pop is impossible; out_ready is ignored.
- Pointers wrap modulo DEPTH.
- retired_count increments by 1 per pop, for all opcodes including SW and opcode >18. It wraps to 0 at 2^COUNT_WIDTH. It is not affected by flush.
- flush=1: queue empties next cycle. Flush has priority over a same-cycle push and pop; neither takes effect and retired_count does not increment.
- Reset mid-operation behaves identically to reset; in-flight entries are discarded.

Test Plan:
- Reset then idle -> out_valid=0, out_wen=0, out_addr=0, out_data=0, retired_count=0, in_ready=1.
- Push opcode 0, rd=5, mem=0xDEADBEEF, alu=0x1234, out_ready=1 -> next cycle out_valid=1, out_wen=1, out_addr=5, out_data=0xDEADBEEF; after the pop, retired_count=1.
- Push opcode 1 (SW), then opcode 3 with rd=0, then opcode 25 with rd=7 -> out_wen=0 for all three, out_data=alu for each, retired_count=3 after all are popped.
- Push two entries with out_ready=0 at DEPTH=2 -> in_ready=0. A third in_valid is not accepted. Raise out_ready -> pops in order, in_ready=1 one cycle after the first pop.
- Continuous in_valid=1 and out_ready=1 for 10 cycles with opcode 4, rd=i, alu=i -> one entry per cycle, in order, no loss or duplication, retired_count=10.
- Queue holding 2 entries; assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, retired_count unchanged.
- COUNT_WIDTH=4: 17 pops -> retired_count=1.
